// File: rtl/br_seq.sv
// ---------------------------------------------------------------------------
// br_seq -- register-bank access sequencer
//
// Takes one operation request at a time over a valid/ready handshake. It reads
// two source registers through the bank's combinational A/B ports, computes a
// result, writes the result back through the bank's write port, and returns
// the result on a response handshake.
//
// Ports
//   clock, reset        : system clock; asynchronous active-low reset
//   req_valid/req_ready : request handshake (ready only while idle)
//   req_op/dst/srca/srcb/imm : operation fields, sampled at the accepting edge
//   rsp_valid/rsp_ready : response handshake; rsp_data carries the result
//   flag_z, flag_c      : zero and carry/borrow of the last executed op
//   Sel_SA, Sel_SB      : bank read addresses; A, B are the read data
//   Sel_SC, Hab_Escrita, E : bank write address, enable and data
// ---------------------------------------------------------------------------
module br_seq #(
  parameter int bits_palavra  = 16,
  parameter int end_registros = 2
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [2:0]               req_op,
  input  logic [end_registros-1:0] req_dst,
  input  logic [end_registros-1:0] req_srca,
  input  logic [end_registros-1:0] req_srcb,
  input  logic [bits_palavra-1:0]  req_imm,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [bits_palavra-1:0]  rsp_data,
  output logic                     flag_z,
  output logic                     flag_c,
  output logic [end_registros-1:0] Sel_SA,
  output logic [end_registros-1:0] Sel_SB,
  output logic [end_registros-1:0] Sel_SC,
  output logic                     Hab_Escrita,
  output logic [bits_palavra-1:0]  E,
  input  logic [bits_palavra-1:0]  A,
  input  logic [bits_palavra-1:0]  B
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    READ  = 3'd1,
    EXEC  = 3'd2,
    WRITE = 3'd3,
    RESP  = 3'd4
  } state_t;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_LDI = 3'b101;
  localparam logic [2:0] OP_CMP = 3'b110;
  localparam logic [2:0] OP_MOV = 3'b111;

  state_t                     state_q, state_d;
  logic [2:0]                 op_q;
  logic [end_registros-1:0]   dst_q, srca_q, srcb_q;
  logic [bits_palavra-1:0]    imm_q;
  logic [bits_palavra-1:0]    opa_q, opb_q;
  logic [bits_palavra-1:0]    result_q;
  logic                       flagz_q, flagc_q;

  logic [bits_palavra-1:0]    aluRes;
  logic                       aluCarry;
  logic [bits_palavra:0]      sumExt, diffExt;

  // State register; an asynchronous reset abandons any operation in flight.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and handshake/write-enable decode.
  always_comb begin
    state_d     = state_q;
    req_ready   = 1'b0;
    rsp_valid   = 1'b0;
    Hab_Escrita = 1'b0;
    unique case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_d = READ;
      end
      READ: state_d = EXEC;
      // CMP only updates the flags, so it skips the write-back cycle.
      EXEC: state_d = (op_q == OP_CMP) ? RESP : WRITE;
      WRITE: begin
        Hab_Escrita = 1'b1;
        state_d     = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // The one-bit extension gives carry-out of the add and borrow of the
  // subtract (borrow is set exactly when A < B unsigned).
  always_comb begin
    sumExt   = {1'b0, opa_q} + {1'b0, opb_q};
    diffExt  = {1'b0, opa_q} - {1'b0, opb_q};
    aluRes   = '0;
    aluCarry = 1'b0;
    unique case (op_q)
      OP_ADD: begin
        aluRes   = sumExt[bits_palavra-1:0];
        aluCarry = sumExt[bits_palavra];
      end
      OP_SUB, OP_CMP: begin
        aluRes   = diffExt[bits_palavra-1:0];
        aluCarry = diffExt[bits_palavra];
      end
      OP_AND:  aluRes = opa_q & opb_q;
      OP_OR:   aluRes = opa_q | opb_q;
      OP_XOR:  aluRes = opa_q ^ opb_q;
      OP_LDI:  aluRes = imm_q;
      OP_MOV:  aluRes = opa_q;
      default: aluRes = '0;
    endcase
  end

  // Request fields are latched only at the accepting edge, so the read
  // addresses keep their last value outside READ. Operands are captured at
  // the end of READ, which makes dst == srca/srcb safe.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      op_q     <= '0;
      dst_q    <= '0;
      srca_q   <= '0;
      srcb_q   <= '0;
      imm_q    <= '0;
      opa_q    <= '0;
      opb_q    <= '0;
      result_q <= '0;
      flagz_q  <= 1'b0;
      flagc_q  <= 1'b0;
    end else begin
      if (state_q == IDLE && req_valid) begin
        op_q   <= req_op;
        dst_q  <= req_dst;
        srca_q <= req_srca;
        srcb_q <= req_srcb;
        imm_q  <= req_imm;
      end
      if (state_q == READ) begin
        opa_q <= A;
        opb_q <= B;
      end
      if (state_q == EXEC) begin
        result_q <= aluRes;
        flagz_q  <= (aluRes == '0);
        flagc_q  <= aluCarry;
      end
    end
  end

  assign Sel_SA   = srca_q;
  assign Sel_SB   = srcb_q;
  assign Sel_SC   = dst_q;
  assign E        = result_q;
  assign rsp_data = result_q;
  assign flag_z   = flagz_q;
  assign flag_c   = flagc_q;

endmodule

// File: doc/br_seq.md
Name: br_seq

Overview:
- Register-bank access sequencer. It is the initiator that drives the register bank's read and write ports.
- Accepts one operation request at a time over a valid/ready handshake.
- Reads two source registers through the bank's combinational A/B ports, computes a 16-bit result, writes it back through the bank's write port, and returns the result on a response handshake.
- Sits between the control unit and the register bank in the datapath.

Parameters:
- bits_palavra, 16, data word width.
- end_registros, 2, register address width.

Ports:
- clock  in  1  system clock; all state updates on posedge.
- reset  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  sequencer can accept a request.
- req_op  in  3  operation code, see Behaviour.
- req_dst  in  end_registros  destination register.
- req_srca  in  end_registros  source register A.
- req_srcb  in  end_registros  source register B.
- req_imm  in  bits_palavra  immediate operand for LDI.
- rsp_valid  out  1  result available.
- rsp_ready  in  1  consumer accepts result.
- rsp_data  out  bits_palavra  operation result.
- flag_z  out  1  zero flag of last executed op.
- flag_c  out  1  carry (ADD) or borrow (SUB/CMP) of last executed op.
- Sel_SA  out  end_registros  bank read address A.
- Sel_SB  out  end_registros  bank read address B.
- Sel_SC  out  end_registros  bank write address.
- Hab_Escrita  out  1  bank write enable.
- E  out  bits_palavra  bank write data.
- A  in  bits_palavra  bank read data A.
- B  in  bits_palavra  bank read data B.

Behaviour:
- Reset (asynchronous, reset=0) forces:
  - state to IDLE;
  - req_ready=1, rsp_valid=0, Hab_Escrita=0;
  - rsp_data, E, flag_z, flag_c, Sel_SA, Sel_SB, Sel_SC all 0.
- Reset mid-operation abandons the operation: no write and no response are issued.
- Opcodes:
  - 000 ADD: A+B.
  - 001 SUB: A-B.
  - 010 AND.
  - 011 OR.
  - 100 XOR.
  - 101 LDI: result = req_imm.
  - 110 CMP: A-B, flags updated, no write.
  - 111 MOV: result = A.
- Arithmetic: all results are bits_palavra wide, modulo 2^bits_palavra (wrap-around).
  - flag_c = carry-out for ADD, borrow (A<B unsigned) for SUB/CMP, 0 for all other ops.
  - flag_z = (result==0) for every op.
  - Flags are registered, update only in EXEC, and hold otherwise.
- FSM states: IDLE, READ, EXEC, WRITE, RESP.
- IDLE:
  - req_ready=1.
  - On posedge with req_valid=1, latch op/dst/srca/srcb/imm and go to READ.
- READ:
  - req_ready=0.
  - Sel_SA=latched srca, Sel_SB=latched srcb.
  - A and B are captured into internal operand registers at the closing edge.
  - Next state is EXEC.
- EXEC:
  - Result and flags computed from the captured operands and registered.
  - Next state is WRITE, or RESP if op=CMP.
- WRITE:
  - Hab_Escrita=1 for exactly this one cycle, with Sel_SC=dst and E=result.
  - Next state is RESP.
- RESP:
  - rsp_valid=1 and rsp_data=result, both held stable while rsp_ready=0.
  - On posedge with rsp_ready=1, go to IDLE.
- Latency: with the request accepted at edge k, rsp_valid rises after edge k+3 (k+2 for CMP).
- Throughput: one op per 5 cycles minimum (4 for CMP). req_ready is high only in IDLE.
- Hab_Escrita is never 1 outside WRITE.
- Sel_SA and Sel_SB hold their last value outside READ.
- dst equal to srca or srcb is legal: operands are captured in READ, before WRITE.
- req_valid arriving while busy is ignored until IDLE. The requester must hold it, per the valid/ready rule.
- req_* fields are don't-care except at the accepting edge.

Test Plan:
- Reset then LDI dst=2, imm=0x0005:
  - exactly one cycle of Hab_Escrita=1 with Sel_SC=2, E=0x0005;
  - rsp_valid after 3 edges with rsp_data=0x0005, flag_z=0, flag_c=0.
- LDI r0=0xFFFF, LDI r1=0x0001, then ADD dst=2, srca=0, srcb=1:
  - E=0x0000, flag_z=1, flag_c=1;
  - a later MOV dst=3, srca=2 returns 0x0000.
- With r0=0xFFFF and r1=0x0001, SUB dst=3, srca=1, srcb=0:
  - rsp_data=0x0002, flag_c=1, flag_z=0.
- CMP srca=1, srcb=1 with r1=0x0001:
  - rsp_data=0x0000, flag_z=1, flag_c=0;
  - Hab_Escrita stays 0 throughout;
  - rsp_valid after 2 edges.
- Backpressure: rsp_ready=0 for 5 cycles, with req_valid=1 and a new request pending:
  - rsp_valid and rsp_data stay stable and req_ready stays 0;
  - after rsp_ready=1, IDLE for 1 cycle, then the new request is accepted.
- Assert reset=0 asynchronously while in WRITE:
  - Hab_Escrita drops immediately and rsp_valid=0;
  - after release, state is IDLE, req_ready=1, and no response appears.
